// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, oversampling constants and parity modes.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
endpackage

// File: rtl/uart_core_param_if.sv
// uart_core_param_if: serial pins, byte FIFO handshake and error flags; UART_LOOPBACK_EN adds loopback.
interface uart_core_param_if #(parameter int DATA_BITS = 8, parameter int DIV_W = 11);
  logic [DIV_W-1:0] baud_div;
  logic rx, tx;
  logic [DATA_BITS-1:0] w_data, r_data;
  logic wr_uart, tx_full, tx_busy, rd_uart, rx_empty;
  logic frame_err, parity_err, overrun_err, clr_err;
`ifdef UART_LOOPBACK_EN
  logic loopback;
`endif
  modport master (
`ifdef UART_LOOPBACK_EN
    output loopback,
`endif
    output baud_div, rx, w_data, wr_uart, rd_uart, clr_err,
    input tx, tx_full, tx_busy, r_data, rx_empty, frame_err, parity_err, overrun_err
  );
  modport slave (
`ifdef UART_LOOPBACK_EN
    input loopback,
`endif
    input baud_div, rx, w_data, wr_uart, rd_uart, clr_err,
    output tx, tx_full, tx_busy, r_data, rx_empty, frame_err, parity_err, overrun_err
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: first-word fall-through FIFO; push into a full FIFO succeeds only with a same-cycle pop.
module uart_fifo #(parameter int W = 8, parameter int AW = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_mem [2**AW];
  logic [AW:0] r_wp, r_rp;
  logic [W-1:0] r_last;
  logic w_push, w_pop;
  assign o_empty = r_wp == r_rp;
  assign o_full = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
  assign w_pop = i_pop & !o_empty;
  assign w_push = i_push & (!o_full | w_pop);
  // r_last keeps the most recent head so the output holds while empty
  assign o_data = o_empty ? r_last : r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_last <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (!o_empty) r_last <= o_data;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised UART with 16x oversampled RX, FIFOs and sticky errors.
// Define UART_LOOPBACK_EN to add the internal TX->RX loopback input.
module uart_core_param #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY = 0,
  parameter int FIFO_AW = 4,
  parameter int DIV_W = 11
) (
  input logic clk,
  input logic rst,
  uart_core_param_if.slave bus
);
  import uart_pkg::*;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID = 4'(MID_SAMPLE);
  localparam logic PODD = PARITY == PAR_ODD;
  localparam logic PEN = PARITY != PAR_NONE;
  logic [DIV_W-1:0] r_cnt, r_div;
  logic w_tick;
  assign w_tick = r_cnt == r_div;
  // divisor is latched at the wrap so a mid-period change waits for the next one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_div <= bus.baud_div;
    end else r_cnt <= r_cnt + 1'b1;
  logic [DATA_BITS-1:0] w_tx_head;
  logic w_tx_empty, w_tx_pop, w_tx_ser, w_rx_in;
  uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .i_push(bus.wr_uart), .i_pop(w_tx_pop), .i_data(bus.w_data),
    .o_data(w_tx_head), .o_full(bus.tx_full), .o_empty(w_tx_empty)
  );
  state_t r_tx_state, w_tx_state;
  logic [3:0] r_tx_tick, w_tx_tick;
  logic [BW-1:0] r_tx_bits, w_tx_bits;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
  logic r_tx_par, w_tx_par, r_tx_stop2, w_tx_stop2;
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_tick = r_tx_tick;
    w_tx_bits = r_tx_bits;
    w_tx_shift = r_tx_shift;
    w_tx_par = r_tx_par;
    w_tx_stop2 = r_tx_stop2;
    w_tx_pop = 1'b0;
    if (w_tick) begin
      w_tx_tick = r_tx_tick + 1'b1;
      case (r_tx_state)
        START: if (r_tx_tick == LAST) begin
          w_tx_state = DATA;
          w_tx_bits = '0;
        end
        DATA: if (r_tx_tick == LAST) begin
          w_tx_shift = r_tx_shift >> 1;
          w_tx_bits = r_tx_bits + 1'b1;
          if (r_tx_bits == BW'(DATA_BITS - 1)) w_tx_state = PEN ? uart_pkg::PARITY : STOP;
        end
        uart_pkg::PARITY: if (r_tx_tick == LAST) w_tx_state = STOP;
        STOP: if (r_tx_tick == LAST) begin
          w_tx_stop2 = 1'b1;
          if (STOP_BITS == 1 || r_tx_stop2) w_tx_state = IDLE;
        end
        default: ;
      endcase
      // loading straight from the end of STOP keeps back-to-back frames gapless
      if (w_tx_state == IDLE && !w_tx_empty) begin
        w_tx_pop = 1'b1;
        w_tx_state = START;
        w_tx_tick = '0;
        w_tx_shift = w_tx_head;
        w_tx_par = ^w_tx_head ^ PODD;
        w_tx_stop2 = 1'b0;
      end
    end
  end
  assign w_tx_ser = (r_tx_state == START) ? 1'b0 : (r_tx_state == DATA) ? r_tx_shift[0] :
                    (r_tx_state == uart_pkg::PARITY) ? r_tx_par : 1'b1;
  assign bus.tx_busy = r_tx_state != IDLE || !w_tx_empty;
`ifdef UART_LOOPBACK_EN
  assign bus.tx = bus.loopback | w_tx_ser;
  assign w_rx_in = bus.loopback ? w_tx_ser : bus.rx;
`else
  assign bus.tx = w_tx_ser;
  assign w_rx_in = bus.rx;
`endif
  logic [1:0] r_rx_sync;
  logic w_rx_s, w_rx_push, w_rx_perr, w_rx_ferr, w_rx_full, w_ovr;
  state_t r_rx_state, w_rx_state;
  logic [3:0] r_rx_tick, w_rx_tick;
  logic [BW-1:0] r_rx_bits, w_rx_bits;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
  assign w_rx_s = r_rx_sync[1];
  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_tick = r_rx_tick;
    w_rx_bits = r_rx_bits;
    w_rx_shift = r_rx_shift;
    w_rx_push = 1'b0;
    w_rx_perr = 1'b0;
    w_rx_ferr = 1'b0;
    if (r_rx_state == IDLE) begin
      if (!w_rx_s) begin
        w_rx_state = START;
        w_rx_tick = '0;
      end
    end else if (w_tick) begin
      w_rx_tick = r_rx_tick + 1'b1;
      case (r_rx_state)
        START: if (r_rx_tick == MID) begin
          w_rx_tick = '0;
          w_rx_bits = '0;
          w_rx_state = w_rx_s ? IDLE : DATA;
        end
        DATA: if (r_rx_tick == LAST) begin
          w_rx_shift = {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
          w_rx_bits = r_rx_bits + 1'b1;
          if (r_rx_bits == BW'(DATA_BITS - 1)) w_rx_state = PEN ? uart_pkg::PARITY : STOP;
        end
        uart_pkg::PARITY: if (r_rx_tick == LAST) begin
          w_rx_perr = w_rx_s != (^r_rx_shift ^ PODD);
          w_rx_state = STOP;
        end
        STOP: if (r_rx_tick == LAST) begin
          w_rx_ferr = !w_rx_s;
          w_rx_push = 1'b1;
          w_rx_state = IDLE;
        end
        default: ;
      endcase
    end
  end
  uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .i_push(w_rx_push), .i_pop(bus.rd_uart), .i_data(r_rx_shift),
    .o_data(bus.r_data), .o_full(w_rx_full), .o_empty(bus.rx_empty)
  );
  assign w_ovr = w_rx_push & w_rx_full & !bus.rd_uart;
  logic r_frame_err, r_parity_err, r_overrun_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tx_state <= IDLE;
      r_tx_tick <= '0;
      r_tx_bits <= '0;
      r_tx_shift <= '0;
      r_tx_par <= 1'b0;
      r_tx_stop2 <= 1'b0;
      r_rx_sync <= 2'b11;
      r_rx_state <= IDLE;
      r_rx_tick <= '0;
      r_rx_bits <= '0;
      r_rx_shift <= '0;
      r_frame_err <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_tick <= w_tx_tick;
      r_tx_bits <= w_tx_bits;
      r_tx_shift <= w_tx_shift;
      r_tx_par <= w_tx_par;
      r_tx_stop2 <= w_tx_stop2;
      r_rx_sync <= {r_rx_sync[0], w_rx_in};
      r_rx_state <= w_rx_state;
      r_rx_tick <= w_rx_tick;
      r_rx_bits <= w_rx_bits;
      r_rx_shift <= w_rx_shift;
      r_frame_err <= w_rx_ferr | (r_frame_err & !bus.clr_err);
      r_parity_err <= w_rx_perr | (r_parity_err & !bus.clr_err);
      r_overrun_err <= w_ovr | (r_overrun_err & !bus.clr_err);
    end
  assign bus.frame_err = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.overrun_err = r_overrun_err;
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: directed checks of an 8N1/depth-16 core and an 8E1/depth-4 core.
module tb_uart_core_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_core_param_if #(.DATA_BITS(8), .DIV_W(11)) bus0 ();
  uart_core_param_if #(.DATA_BITS(8), .DIV_W(11)) bus1 ();
  uart_core_param #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .FIFO_AW(4), .DIV_W(11)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  uart_core_param #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .FIFO_AW(2), .DIV_W(11)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  task automatic wr(input int u, input logic [7:0] d);
    if (u == 0) begin bus0.w_data = d; bus0.wr_uart = 1'b1; end
    else begin bus1.w_data = d; bus1.wr_uart = 1'b1; end
    @(negedge clk);
    bus0.wr_uart = 1'b0;
    bus1.wr_uart = 1'b0;
  endtask

  task automatic rd(input int u);
    if (u == 0) bus0.rd_uart = 1'b1; else bus1.rd_uart = 1'b1;
    @(negedge clk);
    bus0.rd_uart = 1'b0;
    bus1.rd_uart = 1'b0;
  endtask

  task automatic send(input int u, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (u == 0) bus0.rx = bits[i]; else bus1.rx = bits[i];
      repeat (16) @(negedge clk);
    end
    bus0.rx = 1'b1;
    bus1.rx = 1'b1;
  endtask

  task automatic cap_tx0(output logic [9:0] b, output logic busy_a, output logic busy_b, output logic ok);
    ok = 1'b0;
    b = '0;
    busy_a = 1'bx;
    busy_b = 1'bx;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus0.tx === 1'b0) ok = 1'b1;
    end
    if (!ok) return;
    repeat (8) @(negedge clk);
    b[0] = bus0.tx;
    for (int k = 1; k < 10; k++) begin
      repeat (16) @(negedge clk);
      b[k] = bus0.tx;
    end
    repeat (7) @(negedge clk);
    busy_a = bus0.tx_busy;
    @(negedge clk);
    busy_b = bus0.tx_busy;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset;
    bus0.baud_div = '0; bus1.baud_div = '0;
    bus0.rx = 1'b1; bus1.rx = 1'b1;
    bus0.w_data = '0; bus1.w_data = '0;
    bus0.wr_uart = 1'b0; bus1.wr_uart = 1'b0;
    bus0.rd_uart = 1'b0; bus1.rd_uart = 1'b0;
    bus0.clr_err = 1'b0; bus1.clr_err = 1'b0;
`ifdef UART_LOOPBACK_EN
    bus0.loopback = 1'b0; bus1.loopback = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus0.tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", bus0.tx); end
    n_cmp++; if (bus0.tx_full !== 1'b0) begin n_bad++; $display("FAIL reset_tx_full: got %b want 0", bus0.tx_full); end
    n_cmp++; if (bus0.tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_tx_busy: got %b want 0", bus0.tx_busy); end
    n_cmp++; if (bus0.rx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_rx_empty: got %b want 1", bus0.rx_empty); end
    n_cmp++; if (bus0.r_data !== 8'h00) begin n_bad++; $display("FAIL reset_r_data: got %h want 00", bus0.r_data); end
    n_cmp++; if ({bus0.frame_err, bus0.parity_err, bus0.overrun_err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {bus0.frame_err, bus0.parity_err, bus0.overrun_err}); end
  endtask

  task automatic test_tx_frame;
    logic [9:0] b;
    logic ba, bb, ok;
    wr(0, 8'h0F);
    cap_tx0(b, ba, bb, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tx_start_seen: got %b want 1", ok); end
    n_cmp++; if (b !== 10'b1_0000_1111_0) begin n_bad++; $display("FAIL tx_bits_0F: got %b want 1000011110", b); end
    n_cmp++; if (ba !== 1'b1) begin n_bad++; $display("FAIL tx_busy_in_stop: got %b want 1", ba); end
    n_cmp++; if (bb !== 1'b0) begin n_bad++; $display("FAIL tx_busy_after_160: got %b want 0", bb); end
  endtask

  task automatic test_rx;
    send(0, {1'b1, 8'h5A, 1'b0}, 10);
    repeat (4) @(negedge clk);
    n_cmp++; if (bus0.rx_empty !== 1'b0) begin n_bad++; $display("FAIL rx_not_empty: got %b want 0", bus0.rx_empty); end
    n_cmp++; if (bus0.r_data !== 8'h5A) begin n_bad++; $display("FAIL rx_data: got %h want 5a", bus0.r_data); end
    n_cmp++; if ({bus0.frame_err, bus0.parity_err, bus0.overrun_err} !== 3'b000) begin
      n_bad++; $display("FAIL rx_no_flags: got %b want 000", {bus0.frame_err, bus0.parity_err, bus0.overrun_err}); end
    rd(0);
    n_cmp++; if (bus0.rx_empty !== 1'b1) begin n_bad++; $display("FAIL rx_empty_after_pop: got %b want 1", bus0.rx_empty); end
    n_cmp++; if (bus0.r_data !== 8'h5A) begin n_bad++; $display("FAIL rx_data_hold: got %h want 5a", bus0.r_data); end
  endtask

  task automatic test_framing_glitch;
    bus0.rx = 1'b0;
    repeat (3) @(negedge clk);
    bus0.rx = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (bus0.rx_empty !== 1'b1) begin n_bad++; $display("FAIL glitch_no_push: got %b want 1", bus0.rx_empty); end
    send(0, {1'b0, 8'hC3, 1'b0}, 10);
    repeat (30) @(negedge clk);
    n_cmp++; if (bus0.frame_err !== 1'b1) begin n_bad++; $display("FAIL frame_err_set: got %b want 1", bus0.frame_err); end
    n_cmp++; if (bus0.r_data !== 8'hC3) begin n_bad++; $display("FAIL frame_byte_pushed: got %h want c3", bus0.r_data); end
    rd(0);
    n_cmp++; if (bus0.rx_empty !== 1'b1) begin n_bad++; $display("FAIL frame_single_push: got %b want 1", bus0.rx_empty); end
  endtask

  task automatic test_parity;
    send(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    n_cmp++; if (bus1.parity_err !== 1'b1) begin n_bad++; $display("FAIL parity_err_set: got %b want 1", bus1.parity_err); end
    n_cmp++; if (bus1.r_data !== 8'h07) begin n_bad++; $display("FAIL parity_byte_queued: got %h want 07", bus1.r_data); end
    n_cmp++; if (bus1.frame_err !== 1'b0) begin n_bad++; $display("FAIL parity_no_frame_err: got %b want 0", bus1.frame_err); end
    bus1.clr_err = 1'b1;
    @(negedge clk);
    bus1.clr_err = 1'b0;
    n_cmp++; if (bus1.parity_err !== 1'b0) begin n_bad++; $display("FAIL parity_err_clr: got %b want 0", bus1.parity_err); end
    rd(1);
    n_cmp++; if (bus1.rx_empty !== 1'b1) begin n_bad++; $display("FAIL parity_pop: got %b want 1", bus1.rx_empty); end
  endtask

  task automatic test_overrun;
    logic [7:0] exp [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) send(1, {1'b1, ^exp[i], exp[i], 1'b0}, 11);
    repeat (4) @(negedge clk);
    n_cmp++; if (bus1.overrun_err !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b want 1", bus1.overrun_err); end
    n_cmp++; if (bus1.parity_err !== 1'b0) begin n_bad++; $display("FAIL overrun_no_parity: got %b want 0", bus1.parity_err); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus1.r_data !== exp[i]) begin n_bad++; $display("FAIL overrun_order[%0d]: got %h want %h", i, bus1.r_data, exp[i]); end
      rd(1);
    end
    n_cmp++; if (bus1.rx_empty !== 1'b1) begin n_bad++; $display("FAIL overrun_drained: got %b want 1", bus1.rx_empty); end
  endtask

  task automatic test_tx_full;
    logic [7:0] bv [4] = '{8'h12, 8'hB7, 8'h6C, 8'hF0};
    logic [10:0] fb;
    logic ok = 1'b0;
    int c0;
    wr(1, 8'hA0);
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bus1.tx === 1'b0) ok = 1'b1; else @(negedge clk);
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL txfull_start_seen: got %b want 1", ok); end
    c0 = cyc;
    for (int i = 0; i < 4; i++) wr(1, bv[i]);
    n_cmp++; if (bus1.tx_full !== 1'b1) begin n_bad++; $display("FAIL tx_full_after_4: got %b want 1", bus1.tx_full); end
    wr(1, 8'hEE);
    for (int j = 1; j <= 4; j++) begin
      for (int k = 0; k < 11; k++) begin
        wait_to(c0 + 176 * j + 8 + 16 * k);
        fb[k] = bus1.tx;
      end
      n_cmp++; if (fb !== {1'b1, ^bv[j-1], bv[j-1], 1'b0}) begin
        n_bad++; $display("FAIL tx_b2b_frame[%0d]: got %b want %b", j, fb, {1'b1, ^bv[j-1], bv[j-1], 1'b0}); end
    end
    wait_to(c0 + 176 * 5 + 8);
    n_cmp++; if ({bus1.tx, bus1.tx_busy} !== 2'b10) begin
      n_bad++; $display("FAIL tx_fifth_ignored: got tx/busy %b want 10", {bus1.tx, bus1.tx_busy}); end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] b;
    logic ba, bb, ok = 1'b0;
    send(0, {1'b1, 8'h99, 1'b0}, 10);
    wr(0, 8'hA5);
    wr(0, 8'h5A);
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bus0.tx === 1'b0) ok = 1'b1; else @(negedge clk);
    end
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus0.tx !== 1'b1) begin n_bad++; $display("FAIL midrst_tx_high: got %b want 1", bus0.tx); end
    n_cmp++; if (bus0.tx_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus0.tx_busy); end
    n_cmp++; if (bus0.rx_empty !== 1'b1) begin n_bad++; $display("FAIL midrst_rx_empty: got %b want 1", bus0.rx_empty); end
    n_cmp++; if ({bus0.frame_err, bus1.overrun_err} !== 2'b00) begin
      n_bad++; $display("FAIL midrst_flags: got %b want 00", {bus0.frame_err, bus1.overrun_err}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr(0, 8'h3C);
    cap_tx0(b, ba, bb, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL postrst_start_seen: got %b want 1", ok); end
    n_cmp++; if (b !== {1'b1, 8'h3C, 1'b0}) begin n_bad++; $display("FAIL postrst_bits_3C: got %b want %b", b, {1'b1, 8'h3C, 1'b0}); end
    n_cmp++; if (bb !== 1'b0) begin n_bad++; $display("FAIL postrst_idle: got %b want 0", bb); end
  endtask

  initial begin
    test_reset;
    test_tx_frame;
    test_rx;
    test_framing_glitch;
    test_parity;
    test_overrun;
    test_tx_full;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised successor to the fixed 8N1 UART core.
- Configurable data width, parity, stop bits and FIFO depth; 16x-oversampled receiver; sticky error flags.
- Sits between the board serial pins and the microwave controller FSM; its byte interface has the same rd_uart/wr_uart FIFO handshake as the existing UART.

Parameters:
- DATA_BITS, 8, frame data bits, legal 5..9.
- STOP_BITS, 1, stop bits, legal 1 or 2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW per direction.
- DIV_W, 11, baud divisor width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- baud_div  in  DIV_W  oversample tick every baud_div+1 clocks
- rx  in  1  serial input, asynchronous, idle high
- tx  out  1  serial output, idle high
- w_data  in  DATA_BITS  byte to transmit
- wr_uart  in  1  push w_data into TX FIFO
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  TX FSM not IDLE or TX FIFO not empty
- r_data  out  DATA_BITS  head of RX FIFO (first-word fall-through)
- rd_uart  in  1  pop RX FIFO
- rx_empty  out  1  RX FIFO empty
- frame_err  out  1  sticky: stop bit sampled low
- parity_err  out  1  sticky: parity mismatch
- overrun_err  out  1  sticky: RX byte completed while RX FIFO full
- clr_err  in  1  clear all sticky flags

Behaviour:
- Reset values: tx = 1, tx_full = 0, tx_busy = 0, rx_empty = 1, r_data = 0, all error flags 0. Both FIFOs are emptied and both FSMs go to IDLE. A reset mid-frame aborts the frame immediately; tx goes high within the reset assertion.
- Baud generator:
  - Counter runs 0..baud_div; a one-cycle tick fires when count == baud_div, then the counter wraps to 0.
  - baud_div = 0 gives a tick every clock.
  - A change to baud_div takes effect at the next wrap.
- Bit time: 16 ticks.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
  - IDLE: synchronised rx = 0 enters START and clears the tick count.
  - START: at the 8th tick (mid-bit), rx = 1 is a glitch and returns to IDLE with no push; rx = 0 enters DATA.
  - DATA: samples every 16 ticks, LSB first, DATA_BITS samples.
  - PARITY: samples one bit; a mismatch sets parity_err.
  - STOP: samples only the first stop bit; 0 sets frame_err. The byte is pushed at that sample, then the FSM returns to IDLE.
  - A byte with a frame or parity error is still pushed.
  - Push while RX FIFO full: byte dropped, overrun_err set, FIFO contents unchanged. Push and pop in the same cycle on a full FIFO: both succeed, no overrun.
- TX path:
  - FSM states: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
  - IDLE with TX FIFO not empty: pops the head and enters START on the next tick. Each state lasts 16 ticks; STOP lasts 16*STOP_BITS ticks.
  - Back-to-back bytes: no idle gap beyond tick alignment.
- FIFO handshake:
  - wr_uart while tx_full is ignored.
  - rd_uart while rx_empty is ignored; r_data holds its last value while empty.
  - A pop takes effect at the clock edge; the new head is visible the next cycle.
- Error flags: clr_err clears all three sticky flags. If a set event and clr_err occur in the same cycle, set wins.
- Width rules:
  - Parity is XOR over DATA_BITS bits; odd parity inverts the result.
  - Tick counters are 4 bits wide; bit counters are $clog2(DATA_BITS+1) bits wide.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit).
  - loopback = 1 feeds the internal TX serial stream into the RX synchroniser input in place of rx, and forces tx = 1.
  - Switching loopback mid-frame is allowed; a corrupted frame there is acceptable, but the error flags must still behave as specified.
- Not defined: the port is absent and rx feeds the receiver directly.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}, shared by RX and TX;
  - localparams OVERSAMPLE = 16 and MID_SAMPLE = 7;
  - parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN.
- Sub-module uart_fifo (parameters W, AW), instantiated twice: synchronous FWFT, full/empty outputs, same-cycle push/pop when full allowed.
- Baud generator, RX FSM and TX FSM stay inline.

Test Plan:
- TX frame timing: baud_div = 0, 8N1, write 8'h0F -> tx low 16 clocks, then bits 1,1,1,1,0,0,0,0 for 16 clocks each, then high 16 clocks; 160 clocks total; tx_busy falls after stop.
- RX loopback: drive rx with frame 0x5A at 16 clocks/bit, baud_div = 0 -> rx_empty falls; r_data = 8'h5A; rd_uart for one cycle -> rx_empty = 1; no error flags.
- Parity: PARITY = 2, send 0x07 with parity bit 0 (wrong) -> parity_err = 1, byte 0x07 still queued; clr_err pulse -> flag 0.
- Framing and glitch: 3-clock low pulse on rx -> no push. Frame with stop bit 0 -> frame_err = 1, byte pushed.
- Overrun: FIFO_AW = 2, receive 5 bytes without reading -> first 4 retained in order, overrun_err = 1; tx_full asserts after 4 writes; a 5th wr_uart is ignored.
- Reset mid-frame: assert rst during DATA of a TX byte -> tx = 1 immediately, FIFOs empty, flags 0; the next write transmits cleanly.
